// File: rtl/omok_board_engine_if.sv
// Bundle between the cursor/button logic (master) and the Gomoku board engine (slave).
interface omok_board_engine_if #(
  parameter int BOARD_N = 10,
  parameter int PW      = $clog2(BOARD_N*BOARD_N)
);
  logic [PW-1:0]                cur_pos;
  logic                         put;
  logic                         undo;
  logic                         clear;
  logic [BOARD_N*BOARD_N-1:0]   board_state;
  logic [BOARD_N*BOARD_N-1:0]   turn_map;
  logic                         next_turn;
  logic                         busy;
  logic                         accept;
  logic                         reject;
  logic                         game_over;
  logic                         winner;

  modport master (
    output cur_pos, put, undo, clear,
    input  board_state, turn_map, next_turn, busy, accept, reject, game_over, winner
  );

  modport slave (
    input  cur_pos, put, undo, clear,
    output board_state, turn_map, next_turn, busy, accept, reject, game_over, winner
  );
endinterface

// File: rtl/omok_board_engine.sv
// Gomoku board engine: stone storage, turn alternation, undo history and a sequential win scan.
// OMOK_EXACT_FIVE_EN selects the overline rule (a line longer than WIN_LEN does not win).
//
// state | meaning
// IDLE  | waiting for put/undo/clear
// SCAN  | probing the four lines through the stone just placed
// OVER  | win found, puts refused until undo or clear
module omok_board_engine #(
  parameter int BOARD_N    = 10,
  parameter int WIN_LEN    = 5,
  parameter int HIST_DEPTH = 16,
  parameter int PW         = $clog2(BOARD_N*BOARD_N)
) (
  input  logic              clk,
  input  logic              rst,
  omok_board_engine_if.slave bus
);

  localparam int NC = BOARD_N*BOARD_N;
  localparam int CW = $clog2(BOARD_N) + 2;
  localparam int HW = $clog2(HIST_DEPTH);
  localparam int MW = $clog2(2*WIN_LEN + 2);
  localparam int SW = $clog2(WIN_LEN + 1);
`ifdef OMOK_EXACT_FIVE_EN
  localparam int PROBE_L = WIN_LEN;
`else
  localparam int PROBE_L = WIN_LEN - 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OVER} state_t;

  state_t                 state_q, state_d;
  logic [NC-1:0]          board_q, board_d;
  logic [NC-1:0]          turn_q, turn_d;
  logic                   next_turn_q, next_turn_d;
  logic                   busy_q, busy_d;
  logic                   accept_q, accept_d;
  logic                   reject_q, reject_d;
  logic                   game_over_q, game_over_d;
  logic                   winner_q, winner_d;
  logic                   put_prev_q, put_prev_d;
  logic                   undo_prev_q, undo_prev_d;
  logic [PW-1:0]          hist_q [HIST_DEPTH];
  logic [PW-1:0]          hist_d [HIST_DEPTH];
  logic [HW-1:0]          wp_q, wp_d;
  logic [HW:0]            hcnt_q, hcnt_d;
  logic [1:0]             dir_q, dir_d;
  logic                   side_q, side_d;
  logic [SW-1:0]          steps_q, steps_d;
  logic [MW-1:0]          matches_q, matches_d;
  logic                   colour_q, colour_d;
  logic signed [CW-1:0]   org_r_q, org_r_d, org_c_q, org_c_d;
  logic signed [CW-1:0]   prb_r_q, prb_r_d, prb_c_q, prb_c_d;

  function automatic logic [2*CW-1:0] dir_delta(input logic [1:0] d);
    logic signed [CW-1:0] r;
    logic signed [CW-1:0] c;
    r = '0;
    c = '0;
    case (d)
      2'd0:    begin r = CW'(0); c = CW'(1);  end
      2'd1:    begin r = CW'(1); c = CW'(0);  end
      2'd2:    begin r = CW'(1); c = CW'(1);  end
      default: begin r = CW'(1); c = -CW'(1); end
    endcase
    return {r, c};
  endfunction

  logic                 put_edge, undo_edge, pos_ok, in_bounds, probe_match, side_done, win_hit;
  logic signed [CW-1:0] cur_row, cur_col, cur_dr, cur_dc, nxt_dr, nxt_dc, d0_r, d0_c, step_r, step_c;
  logic [PW-1:0]        prb_idx, pop_pos;
  logic [MW-1:0]        total;

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    turn_d      = turn_q;
    next_turn_d = next_turn_q;
    busy_d      = busy_q;
    accept_d    = 1'b0;
    reject_d    = 1'b0;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    put_prev_d  = bus.put;
    undo_prev_d = bus.undo;
    hist_d      = hist_q;
    wp_d        = wp_q;
    hcnt_d      = hcnt_q;
    dir_d       = dir_q;
    side_d      = side_q;
    steps_d     = steps_q;
    matches_d   = matches_q;
    colour_d    = colour_q;
    org_r_d     = org_r_q;
    org_c_d     = org_c_q;
    prb_r_d     = prb_r_q;
    prb_c_d     = prb_c_q;
    side_done   = 1'b0;
    win_hit     = 1'b0;
    total       = '0;

    put_edge  = bus.put & ~put_prev_q;
    undo_edge = bus.undo & ~undo_prev_q;
    pos_ok    = ({1'b0, bus.cur_pos} < (PW+1)'(NC)) && !board_q[bus.cur_pos];
    cur_row   = CW'(bus.cur_pos / PW'(BOARD_N));
    cur_col   = CW'(bus.cur_pos % PW'(BOARD_N));
    pop_pos   = hist_q[wp_q - HW'(1)];

    {cur_dr, cur_dc} = dir_delta(dir_q);
    {nxt_dr, nxt_dc} = dir_delta(dir_q + 2'd1);
    {d0_r, d0_c}     = dir_delta(2'd0);
    step_r = side_q ? -cur_dr : cur_dr;
    step_c = side_q ? -cur_dc : cur_dc;

    // Row/col bounds are checked before the flat index is trusted, so lines never wrap.
    in_bounds   = !prb_r_q[CW-1] && (prb_r_q < CW'(BOARD_N)) &&
                  !prb_c_q[CW-1] && (prb_c_q < CW'(BOARD_N));
    prb_idx     = PW'(prb_r_q) * PW'(BOARD_N) + PW'(prb_c_q);
    probe_match = in_bounds && board_q[prb_idx] && (turn_q[prb_idx] == colour_q);

    if (bus.clear) begin
      state_d     = S_IDLE;
      board_d     = '0;
      turn_d      = '0;
      next_turn_d = 1'b0;
      busy_d      = 1'b0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
      hist_d      = '{default: '0};
      wp_d        = '0;
      hcnt_d      = '0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (undo_edge) begin
            if (hcnt_q != '0) begin
              board_d[pop_pos] = 1'b0;
              turn_d[pop_pos]  = 1'b0;
              next_turn_d      = ~next_turn_q;
              wp_d             = wp_q - HW'(1);
              hcnt_d           = hcnt_q - (HW+1)'(1);
              game_over_d      = 1'b0;
              winner_d         = 1'b0;
              state_d          = S_IDLE;
            end
          end else if (put_edge) begin
            if (state_q == S_OVER || !pos_ok) begin
              reject_d = 1'b1;
            end else begin
              board_d[bus.cur_pos] = 1'b1;
              turn_d[bus.cur_pos]  = next_turn_q;
              hist_d[wp_q]         = bus.cur_pos;
              wp_d                 = wp_q + HW'(1);
              // A full history overwrites its oldest entry, so the count saturates.
              if (hcnt_q != (HW+1)'(HIST_DEPTH)) hcnt_d = hcnt_q + (HW+1)'(1);
              next_turn_d = ~next_turn_q;
              colour_d    = next_turn_q;
              accept_d    = 1'b1;
              busy_d      = 1'b1;
              state_d     = S_SCAN;
              org_r_d     = cur_row;
              org_c_d     = cur_col;
              prb_r_d     = cur_row + d0_r;
              prb_c_d     = cur_col + d0_c;
              dir_d       = 2'd0;
              side_d      = 1'b0;
              steps_d     = '0;
              matches_d   = '0;
            end
          end
        end
        S_SCAN: begin
          side_done = 1'b1;
          if (probe_match) begin
            matches_d = matches_q + MW'(1);
            steps_d   = steps_q + SW'(1);
            if ((steps_q + SW'(1)) < SW'(PROBE_L)) begin
              side_done = 1'b0;
              prb_r_d   = prb_r_q + step_r;
              prb_c_d   = prb_c_q + step_c;
            end
          end
          if (side_done) begin
            steps_d = '0;
            if (!side_q) begin
              side_d  = 1'b1;
              prb_r_d = org_r_q - cur_dr;
              prb_c_d = org_c_q - cur_dc;
            end else begin
              total = matches_d + MW'(1);
`ifdef OMOK_EXACT_FIVE_EN
              win_hit = (total == MW'(WIN_LEN));
`else
              win_hit = (total >= MW'(WIN_LEN));
`endif
              if (win_hit) begin
                game_over_d = 1'b1;
                winner_d    = colour_q;
                busy_d      = 1'b0;
                state_d     = S_OVER;
              end else if (dir_q == 2'd3) begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end else begin
                dir_d     = dir_q + 2'd1;
                side_d    = 1'b0;
                matches_d = '0;
                prb_r_d   = org_r_q + nxt_dr;
                prb_c_d   = org_c_q + nxt_dc;
              end
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      board_q     <= '0;
      turn_q      <= '0;
      next_turn_q <= 1'b0;
      busy_q      <= 1'b0;
      accept_q    <= 1'b0;
      reject_q    <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      put_prev_q  <= 1'b0;
      undo_prev_q <= 1'b0;
      hist_q      <= '{default: '0};
      wp_q        <= '0;
      hcnt_q      <= '0;
      dir_q       <= '0;
      side_q      <= 1'b0;
      steps_q     <= '0;
      matches_q   <= '0;
      colour_q    <= 1'b0;
      org_r_q     <= '0;
      org_c_q     <= '0;
      prb_r_q     <= '0;
      prb_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      turn_q      <= turn_d;
      next_turn_q <= next_turn_d;
      busy_q      <= busy_d;
      accept_q    <= accept_d;
      reject_q    <= reject_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      put_prev_q  <= put_prev_d;
      undo_prev_q <= undo_prev_d;
      hist_q      <= hist_d;
      wp_q        <= wp_d;
      hcnt_q      <= hcnt_d;
      dir_q       <= dir_d;
      side_q      <= side_d;
      steps_q     <= steps_d;
      matches_q   <= matches_d;
      colour_q    <= colour_d;
      org_r_q     <= org_r_d;
      org_c_q     <= org_c_d;
      prb_r_q     <= prb_r_d;
      prb_c_q     <= prb_c_d;
    end
  end

  assign bus.board_state = board_q;
  assign bus.turn_map    = turn_q;
  assign bus.next_turn   = next_turn_q;
  assign bus.busy        = busy_q;
  assign bus.accept      = accept_q;
  assign bus.reject      = reject_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_omok_board_engine.sv
// Scoreboard bench for omok_board_engine: a board model predicts every put/undo/clear outcome.
module tb_omok_board_engine;
  localparam int N  = 10;
  localparam int WL = 5;
  localparam int HD = 4;
  localparam int NC = N*N;
  localparam int PW = $clog2(NC);
`ifdef OMOK_EXACT_FIVE_EN
  localparam int LP = WL;
`else
  localparam int LP = WL - 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  omok_board_engine_if #(.BOARD_N(N)) bus ();

  omok_board_engine #(.BOARD_N(N), .WIN_LEN(WL), .HIST_DEPTH(HD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit            acc;
    logic [NC-1:0] brd;
    logic [NC-1:0] trn;
    bit            nt;
    bit            go;
    bit            win;
  } exp_t;

  exp_t exp_q[$];
  bit   mb[NC];
  bit   mc[NC];
  int   hist[$];
  bit   m_nt, m_go, m_win;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [NC-1:0] vec_b();
    logic [NC-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i] = mb[i];
    return v;
  endfunction

  function automatic logic [NC-1:0] vec_t();
    logic [NC-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i] = mb[i] & mc[i];
    return v;
  endfunction

  // Full run length through pos in each of the four line directions.
  function automatic bit model_wins(input int pos);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    int r0 = pos / N;
    int c0 = pos % N;
    bit col = mc[pos];
    for (int d = 0; d < 4; d++) begin
      int n = 1;
      for (int s = -1; s <= 1; s += 2) begin
        int r = r0 + s*dr[d];
        int c = c0 + s*dc[d];
        while (r >= 0 && r < N && c >= 0 && c < N && mb[r*N+c] && mc[r*N+c] == col) begin
          n++;
          r += s*dr[d];
          c += s*dc[d];
        end
      end
`ifdef OMOK_EXACT_FIVE_EN
      if (n == WL) return 1'b1;
`else
      if (n >= WL) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin mb[i] = 1'b0; mc[i] = 1'b0; end
    hist.delete();
    m_nt = 1'b0; m_go = 1'b0; m_win = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_board"}, bus.board_state, vec_b());
    chk({tag, "_turn_map"}, bus.turn_map, vec_t());
    chk({tag, "_next_turn"}, bus.next_turn, m_nt);
    chk({tag, "_game_over"}, bus.game_over, m_go);
    chk({tag, "_winner"}, bus.winner, m_win);
  endtask

  task automatic settle();
    int k;
    k = 0;
    while (bus.busy && k < 60) begin @(negedge clk); k++; end
    chk("busy_released", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("pulse_seen", exp_q.size(), 0);
  endtask

  task automatic do_put(input int pos);
    exp_t e;
    bit ok;
    ok = (pos < NC) ? (!mb[pos] && !m_go) : 1'b0;
    if (ok) begin
      mb[pos] = 1'b1;
      mc[pos] = m_nt;
      hist.push_back(pos);
      if (hist.size() > HD) void'(hist.pop_front());
      if (model_wins(pos)) begin m_go = 1'b1; m_win = m_nt; end
      m_nt = ~m_nt;
    end
    e.acc = ok; e.brd = vec_b(); e.trn = vec_t(); e.nt = m_nt; e.go = m_go; e.win = m_win;
    exp_q.push_back(e);
    @(negedge clk);
    bus.cur_pos = PW'(pos);
    bus.put = 1'b1;
    @(negedge clk);
    bus.put = 1'b0;
    settle();
  endtask

  task automatic do_undo();
    if (hist.size() > 0) begin
      int p;
      p = hist.pop_back();
      mb[p] = 1'b0; mc[p] = 1'b0;
      m_nt = ~m_nt; m_go = 1'b0; m_win = 1'b0;
    end
    @(negedge clk);
    bus.undo = 1'b1;
    @(negedge clk);
    bus.undo = 1'b0;
    chk_state("undo");
    @(negedge clk);
  endtask

  task automatic do_clear();
    model_reset();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk_state("clear");
  endtask

  initial begin : monitor
    exp_t e;
    int k;
    forever begin
      @(negedge clk);
      if (mon_en && rst && (bus.accept || bus.reject)) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pulse: got accept=%0b reject=%0b, expected none", bus.accept, bus.reject);
        end else begin
          e = exp_q.pop_front();
          chk("accept", bus.accept, e.acc);
          chk("reject", bus.reject, !e.acc);
          chk("board", bus.board_state, e.brd);
          chk("turn_map", bus.turn_map, e.trn);
          chk("next_turn", bus.next_turn, e.nt);
          k = 0;
          while (bus.busy && k < 60) begin @(negedge clk); k++; end
          chk("scan_len_in_bound", (k <= 8*LP), 1'b1);
          chk("game_over", bus.game_over, e.go);
          chk("winner", bus.winner, e.win);
        end
      end
    end
  end

  initial begin
    int seq1[9] = '{0, 10, 1, 11, 2, 12, 3, 13, 4};
    int seq2[9] = '{7, 50, 8, 52, 9, 54, 10, 56, 11};
    int seq6[11] = '{20, 40, 21, 42, 23, 44, 24, 46, 25, 48, 22};
    rst = 1'b0;
    bus.cur_pos = '0; bus.put = 1'b0; bus.undo = 1'b0; bus.clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.board_state, bus.turn_map, bus.next_turn, bus.busy, bus.accept,
                          bus.reject, bus.game_over, bus.winner}, '0);
    rst = 1'b1;
    @(negedge clk);

    // Horizontal five for black, then undo and replay the winning stone.
    foreach (seq1[i]) do_put(seq1[i]);
    chk("row_win_over", bus.game_over, 1'b1);
    chk("row_win_black", bus.winner, 1'b0);
    do_put(50);
    do_undo();
    chk("undo_bit4", bus.board_state[4], 1'b0);
    chk("undo_next_turn", bus.next_turn, 1'b0);
    do_put(4);
    chk("rewin_over", bus.game_over, 1'b1);
    do_clear();

    // Consecutive indices across a row end are not a line.
    foreach (seq2[i]) do_put(seq2[i]);
    chk("no_wrap_win", bus.game_over, 1'b0);
    do_clear();

    do_put(45);
    do_put(45);
    do_put(100);
    do_put(127);
    chk("dup_single_bit", bus.board_state, (128'd1 << 45));
    chk("dup_next_turn", bus.next_turn, 1'b1);
    do_clear();

    // Six stones with a four-deep history: only four can be taken back.
    for (int i = 0; i < 6; i++) do_put(60 + 2*i);
    for (int i = 0; i < 5; i++) do_undo();
    chk("hist_remaining", $countones(bus.board_state), 2);
    chk("hist_oldest_kept", {bus.board_state[62], bus.board_state[60]}, 2'b11);
    do_clear();

    // Six in a row completed from the inside.
    foreach (seq6[i]) do_put(seq6[i]);
`ifdef OMOK_EXACT_FIVE_EN
    chk("overline_no_win", bus.game_over, 1'b0);
`else
    chk("overline_win", bus.game_over, 1'b1);
`endif
    do_clear();

    // Reset while scanning.
    do_put(33);
    mon_en = 1'b0;
    @(negedge clk);
    bus.cur_pos = PW'(55);
    bus.put = 1'b1;
    @(negedge clk);
    bus.put = 1'b0;
    chk("midscan_accept_busy", {bus.accept, bus.busy}, 2'b11);
    #2 rst = 1'b0;
    #1 chk("midscan_reset_outputs", {bus.board_state, bus.turn_map, bus.next_turn, bus.busy,
                                     bus.accept, bus.reject, bus.game_over, bus.winner}, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    do_put(55);
    chk("post_reset_black", {bus.board_state[55], bus.turn_map[55], bus.next_turn}, 3'b101);

    // Random play clustered in a corner so lines actually form.
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) do_clear();
      else if (r < 20) do_undo();
      else if (r < 25) do_put($urandom_range(100, 127));
      else do_put($urandom_range(0, 4) * N + $urandom_range(0, 4));
      if (m_go && $urandom_range(0, 3) == 0) do_clear();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
